// File: rtl/scalar_mult_sched.sv
// Left-to-right double-and-add sequencer for Q = k*P. Loads k, Px and Py
// from a 64-bit stream, then drives one DBL/ADD at a time into an external point adder.
module scalar_mult_sched #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PATN_W = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic              o_op_dbl,
  output logic [PATN_W-1:0] o_op_x1,
  output logic [PATN_W-1:0] o_op_y1,
  output logic [PATN_W-1:0] o_op_z1,
  output logic [PATN_W-1:0] o_op_x2,
  output logic [PATN_W-1:0] o_op_y2,
  input  logic              i_res_valid,
  output logic              o_res_ready,
  input  logic [PATN_W-1:0] i_res_x,
  input  logic [PATN_W-1:0] i_res_y,
  input  logic [PATN_W-1:0] i_res_z,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [PATN_W-1:0] o_out_x,
  output logic [PATN_W-1:0] o_out_y,
  output logic [PATN_W-1:0] o_out_z,
  output logic              o_busy
);

  localparam int unsigned IO_CYCLE = PATN_W / DATA_W;
  localparam int unsigned BEATS    = 3 * IO_CYCLE;
  localparam int unsigned IDX_W    = $clog2(PATN_W);
  localparam int unsigned BEAT_W   = 4;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [PATN_W-1:0] k_q, k_d, px_q, px_d, py_q, py_d;
  logic [PATN_W-1:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              dbl_q, dbl_d;
  logic              in_ready_q, in_ready_d;
  logic              op_valid_q, op_valid_d;
  logic              res_ready_q, res_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  // Next-state, datapath and registered handshake-flag decode
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    px_d    = px_q;
    py_d    = py_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rz_d    = rz_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    dbl_d   = dbl_q;

    case (state_q)
      S_LOAD: begin
        // k, Px, Py form one long shift chain, MS beat of k entering first
        if (i_in_valid && in_ready_q) begin
          k_d  = {k_q[PATN_W-DATA_W-1:0], px_q[PATN_W-1 -: DATA_W]};
          px_d = {px_q[PATN_W-DATA_W-1:0], py_q[PATN_W-1 -: DATA_W]};
          py_d = {py_q[PATN_W-DATA_W-1:0], i_in_data};
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            idx_d   = IDX_W'(PATN_W - 1);
            state_d = S_SCAN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_SCAN: begin
        if (k_q[idx_q]) begin
          rx_d = px_q;
          ry_d = py_q;
          rz_d = PATN_W'(1);
          if (idx_q == '0) begin
            state_d = S_OUT;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            dbl_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end else if (idx_q == '0) begin
          rx_d    = '0;
          ry_d    = PATN_W'(1);
          rz_d    = '0;
          state_d = S_OUT;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_ISSUE: begin
        if (i_op_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // idx already points at the bit that this DBL is working on
        if (i_res_valid) begin
          rx_d = i_res_x;
          ry_d = i_res_y;
          rz_d = i_res_z;
          if (dbl_q && k_q[idx_q]) begin
            dbl_d   = 1'b0;
            state_d = S_ISSUE;
          end else if (idx_q == '0) begin
            state_d = S_OUT;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            dbl_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_OUT: begin
        if (i_out_ready) begin
          k_d     = '0;
          px_d    = '0;
          py_d    = '0;
          rx_d    = '0;
          ry_d    = '0;
          rz_d    = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    op_valid_d  = (state_d == S_ISSUE);
    res_ready_d = (state_d == S_WAIT);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_LOAD);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_LOAD;
      k_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      rz_q        <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      dbl_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      op_valid_q  <= 1'b0;
      res_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      px_q        <= px_d;
      py_q        <= py_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      rz_q        <= rz_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      dbl_q       <= dbl_d;
      in_ready_q  <= in_ready_d;
      op_valid_q  <= op_valid_d;
      res_ready_q <= res_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_op_valid  = op_valid_q;
  assign o_res_ready = res_ready_q;
  assign o_out_valid = out_valid_q;
  assign o_busy      = busy_q;
  assign o_op_dbl    = dbl_q;
  assign o_op_x1     = rx_q;
  assign o_op_y1     = ry_q;
  assign o_op_z1     = rz_q;
  assign o_op_x2     = px_q;
  assign o_op_y2     = py_q;
  assign o_out_x     = rx_q;
  assign o_out_y     = ry_q;
  assign o_out_z     = rz_q;

endmodule

// File: tb/tb_scalar_mult_sched.sv
// Bench for scalar_mult_sched: table of scalars run against a stand-in adder
// (additive toy group, z counts ops), plus reset-during-WAIT sequence.
module tb_scalar_mult_sched;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PATN_W = 256;
  typedef logic [PATN_W-1:0] word_t;

  localparam word_t GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam word_t GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data = '0;
  logic              o_op_valid;
  logic              i_op_ready = 1'b0;
  logic              o_op_dbl;
  word_t             o_op_x1, o_op_y1, o_op_z1, o_op_x2, o_op_y2;
  logic              i_res_valid = 1'b0;
  logic              o_res_ready;
  word_t             i_res_x = '0, i_res_y = '0, i_res_z = '0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b0;
  word_t             o_out_x, o_out_y, o_out_z;
  logic              o_busy;

  int checks   = 0;
  int failures = 0;

  scalar_mult_sched #(.DATA_W(DATA_W), .PATN_W(PATN_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_op_valid(o_op_valid), .i_op_ready(i_op_ready), .o_op_dbl(o_op_dbl),
    .o_op_x1(o_op_x1), .o_op_y1(o_op_y1), .o_op_z1(o_op_z1),
    .o_op_x2(o_op_x2), .o_op_y2(o_op_y2),
    .i_res_valid(i_res_valid), .o_res_ready(o_res_ready),
    .i_res_x(i_res_x), .i_res_y(i_res_y), .i_res_z(i_res_z),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_x(o_out_x), .o_out_y(o_out_y), .o_out_z(o_out_z),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit go(input bit stall);
    return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic load(input word_t k, input word_t px, input word_t py, input bit stall);
    word_t w;
    int    sent = 0;
    int    cyc  = 0;
    bit    fire;
    while (sent < 12 && cyc < 2000) begin
      w = (sent < 4) ? k : (sent < 8) ? px : py;
      i_in_data  = w[PATN_W-1-DATA_W*(sent%4) -: DATA_W];
      i_in_valid = go(stall);
      fire = i_in_valid && o_in_ready;
      @(posedge i_clk); #1;
      cyc++;
      if (fire) sent++;
    end
    i_in_valid = 1'b0;
    chk_int("load_beats", sent, 12);
  endtask

  task automatic serve(input word_t k, input bit stall, input int exp_ndbl,
                       input int exp_nadd, input int exp_lat, input string tag);
    bit    exp_dbl[$];
    int    msb = -1;
    word_t ex, ey, ez, rx, ry, rz, ox, oy, oz, gk_x, gk_y;
    int    nops = 0, ndbl = 0, nadd = 0, t = 0, first = -1;
    bit    done = 1'b0, res_avail = 1'b0, op_fire, res_fire, out_fire, cur_dbl;
    ox = '0; oy = '0; oz = '0; rx = '0; ry = '0; rz = '0;
    cur_dbl = 1'b0;
    for (int i = PATN_W - 1; i >= 0; i--) if (k[i] && msb < 0) msb = i;
    for (int i = msb - 1; i >= 0; i--) begin
      exp_dbl.push_back(1'b1);
      if (k[i]) exp_dbl.push_back(1'b0);
    end
    ex = GX; ey = GY; ez = word_t'(1);
    chk({tag, " busy_scan"}, word_t'(o_busy), word_t'(1));
    while (!done && t < 20000) begin
      op_fire = 1'b0; res_fire = 1'b0; out_fire = 1'b0;
      i_op_ready = 1'b0; i_res_valid = 1'b0; i_out_ready = 1'b0; i_in_valid = 1'b0;
      if (stall) begin
        i_in_valid = 1'($urandom_range(0, 1));
        i_in_data  = {$urandom, $urandom};
      end
      if (o_op_valid) begin
        if (first < 0) first = t;
        if (nops < exp_dbl.size()) begin
          chk({tag, " op_dbl"}, word_t'(o_op_dbl), word_t'(exp_dbl[nops]));
          chk({tag, " op_x1"}, o_op_x1, ex);
          chk({tag, " op_y1"}, o_op_y1, ey);
          chk({tag, " op_z1"}, o_op_z1, ez);
          chk({tag, " op_x2"}, o_op_x2, GX);
          chk({tag, " op_y2"}, o_op_y2, GY);
        end else begin
          chk_int({tag, " extra_op"}, nops, exp_dbl.size() - 1);
        end
        cur_dbl = o_op_dbl;
        rx = o_op_dbl ? o_op_x1 + o_op_x1 : o_op_x1 + o_op_x2;
        ry = o_op_dbl ? o_op_y1 + o_op_y1 : o_op_y1 + o_op_y2;
        rz = o_op_z1 + word_t'(1);
        i_op_ready = go(stall);
        op_fire = i_op_ready;
      end else if (stall) begin
        i_op_ready = 1'($urandom_range(0, 1));
      end
      if (o_res_ready && res_avail) begin
        i_res_x = rx; i_res_y = ry; i_res_z = rz;
        i_res_valid = go(stall);
        res_fire = i_res_valid;
      end else if (stall) begin
        i_res_x = {8{$urandom}}; i_res_y = {8{$urandom}}; i_res_z = {8{$urandom}};
        i_res_valid = 1'($urandom_range(0, 1));
      end
      if (o_out_valid) begin
        if (first < 0) first = t;
        ox = o_out_x; oy = o_out_y; oz = o_out_z;
        i_out_ready = go(stall);
        out_fire = i_out_ready;
      end else if (stall) begin
        i_out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge i_clk); #1;
      t++;
      if (op_fire) begin
        nops++;
        if (cur_dbl) ndbl++; else nadd++;
        res_avail = 1'b1;
      end
      if (res_fire) begin
        res_avail = 1'b0;
        ex = rx; ey = ry; ez = rz;
        chk({tag, " no_bubble"}, word_t'(o_op_valid || o_out_valid), word_t'(1));
      end
      if (out_fire) begin
        done = 1'b1;
        chk({tag, " busy_after_out"}, word_t'(o_busy), word_t'(0));
        chk({tag, " in_ready_after_out"}, word_t'(o_in_ready), word_t'(1));
      end
    end
    i_op_ready = 1'b0; i_res_valid = 1'b0; i_out_ready = 1'b0; i_in_valid = 1'b0;
    chk({tag, " done_in_budget"}, word_t'(done), word_t'(1));
    chk_int({tag, " n_dbl"}, ndbl, exp_ndbl);
    chk_int({tag, " n_add"}, nadd, exp_nadd);
    if (!stall) chk_int({tag, " latency"}, first, exp_lat);
    if (k == '0) begin
      gk_x = '0; gk_y = word_t'(1); ez = '0;
    end else begin
      gk_x = k * GX; gk_y = k * GY; ez = word_t'(1 + exp_ndbl + exp_nadd);
    end
    chk({tag, " out_x"}, ox, gk_x);
    chk({tag, " out_y"}, oy, gk_y);
    chk({tag, " out_z"}, oz, ez);
  endtask

  typedef struct {
    word_t k;
    bit    stall;
    int    ndbl;
    int    nadd;
    int    lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{256'h0,    1'b0, 0,   0,   256};
    vecs[1] = '{256'h1,    1'b0, 0,   0,   256};
    vecs[2] = '{256'h3,    1'b0, 1,   1,   255};
    vecs[3] = '{256'hA5,   1'b0, 7,   3,   249};
    vecs[4] = '{256'h2,    1'b0, 1,   0,   255};
    vecs[5] = '{{1'b1, 255'h0}, 1'b0, 255, 0, 1};
    vecs[6] = '{{256{1'b1}}, 1'b0, 255, 255, 1};
    vecs[7] = '{256'hA5,   1'b1, 7,   3,   0};
    vecs[8] = '{{1'b1, 254'h0, 1'b1}, 1'b1, 255, 1, 0};
    vecs[9] = '{256'h0,    1'b1, 0,   0,   0};

    #12;
    chk("rst_in_ready", word_t'(o_in_ready), word_t'(0));
    chk("rst_busy", word_t'(o_busy), word_t'(0));
    chk("rst_valids", word_t'({o_op_valid, o_res_ready, o_out_valid}), word_t'(0));
    chk("rst_out_y", o_out_y, '0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("in_ready_after_release", word_t'(o_in_ready), word_t'(1));

    for (int v = 0; v < 10; v++) begin
      load(vecs[v].k, GX, GY, vecs[v].stall);
      serve(vecs[v].k, vecs[v].stall, vecs[v].ndbl, vecs[v].nadd, vecs[v].lat,
            $sformatf("vec%0d", v));
    end

    // Reset pulse while an op result is outstanding
    load(256'h5, GX, GY, 1'b0);
    begin
      int guard = 0;
      while (!o_op_valid && guard < 400) begin
        @(posedge i_clk); #1;
        guard++;
      end
      chk("rst_seq_op_seen", word_t'(o_op_valid), word_t'(1));
      i_op_ready = 1'b1;
      @(posedge i_clk); #1;
      i_op_ready = 1'b0;
      chk("rst_seq_in_wait", word_t'(o_res_ready), word_t'(1));
    end
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_res_ready", word_t'(o_res_ready), word_t'(0));
    chk("async_rst_busy", word_t'(o_busy), word_t'(0));
    chk("async_rst_in_ready", word_t'(o_in_ready), word_t'(0));
    chk("async_rst_op_x1", o_op_x1, '0);
    chk("async_rst_op_x2", o_op_x2, '0);
    chk("async_rst_op_valid", word_t'(o_op_valid), word_t'(0));
    @(posedge i_clk); #3;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    load(256'h2, GX, GY, 1'b0);
    serve(256'h2, 1'b0, 1, 0, 255, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
